// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants and the write-request record used by the write-port arbiter.
package regfile_pkg;

  localparam int NREGS   = 16;
  localparam int RADDR_W = 4;
  localparam logic [RADDR_W-1:0] ZERO_REG_ADDR = 4'hF;

  // Widest write data the register file supports; narrower datapaths use the low bits.
  localparam int MAX_DATA_W = 64;

  typedef struct packed {
    logic [RADDR_W-1:0]    addr;
    logic [MAX_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Combinational round-robin arbiter over ports LO..N-1, searching upward from the pointer with wrap.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int LO = 1,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_next_ptr
);

  int          w_idx;
  logic        w_found;
  logic [PW-1:0] w_sel;

  always_comb begin
    o_grant    = '0;
    o_next_ptr = i_ptr;
    w_found    = 1'b0;
    w_idx      = 0;
    w_sel      = '0;
    for (int off = 0; off < N - LO; off++) begin
      // ptr + off never exceeds one wrap, so a single subtraction folds it back into LO..N-1.
      w_idx = int'(i_ptr) + off;
      if (w_idx >= N) w_idx = w_idx - (N - LO);
      w_sel = PW'(w_idx);
      if (!w_found && i_req[w_sel]) begin
        w_found        = 1'b1;
        o_grant[w_sel] = 1'b1;
        o_next_ptr     = (w_idx == N - 1) ? PW'(LO) : PW'(w_idx + 1);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single write-port arbiter: port-0 priority override, round-robin for the rest, one registered write stage.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DATA_W      = 64,
  parameter int P0_PRIORITY = 1,
  parameter int ZERO_REG    = 1,
  localparam int GW         = $clog2(NREQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         hold,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0][RADDR_W-1:0] req_addr,
  input  logic [NREQ-1:0][DATA_W-1:0]  req_data,
  output logic [NREQ-1:0]              req_ready,
  output logic                         RegWrite,
  output logic [RADDR_W-1:0]           wr_addr,
  output logic [DATA_W-1:0]            wr_data,
  output logic [GW-1:0]                grant_id,
  output logic [NREGS-1:0]             pending_mask
);

  localparam int RR_LO = (P0_PRIORITY != 0) ? 1 : 0;

  logic [GW-1:0]      r_ptr;
  logic [NREQ-1:0]    w_rr_req;
  logic [NREQ-1:0]    w_rr_grant;
  logic [GW-1:0]      w_rr_next;
  logic [NREQ-1:0]    w_ready;
  logic               w_p0_win;
  logic               w_fire;
  logic               w_commit;
  logic [GW-1:0]      w_sel_id;
  logic [RADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;

  always_comb begin
    w_rr_req = req_valid;
    if (P0_PRIORITY != 0) w_rr_req[0] = 1'b0;
  end

  rr_arbiter #(.N(NREQ), .LO(RR_LO), .PW(GW)) u_rr (
    .i_req      (w_rr_req),
    .i_ptr      (r_ptr),
    .o_grant    (w_rr_grant),
    .o_next_ptr (w_rr_next)
  );

  assign w_p0_win = (P0_PRIORITY != 0) && req_valid[0];

  always_comb begin
    w_ready = '0;
    if (!hold && !reset) w_ready = w_p0_win ? NREQ'(1) : w_rr_grant;
  end

  assign req_ready = w_ready;
  assign w_fire    = |w_ready;

  always_comb begin
    w_sel_id = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_ready[i]) w_sel_id = GW'(i);
  end

  assign w_sel_addr = req_addr[w_sel_id];
  assign w_sel_data = req_data[w_sel_id];
  // A write to the hardwired zero register still handshakes but never reaches the register file.
  assign w_commit   = w_fire && !((ZERO_REG != 0) && (w_sel_addr == ZERO_REG_ADDR));

  always_comb begin
    pending_mask = '0;
    if (RegWrite) pending_mask[wr_addr] = 1'b1;
    if (w_commit) pending_mask[w_sel_addr] = 1'b1;
  end

  // Output stage: one registered write per cycle, pointer advances only on round-robin grants.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      grant_id <= '0;
      r_ptr    <= GW'(RR_LO);
    end else begin
      RegWrite <= w_commit;
      if (w_commit) begin
        wr_addr  <= w_sel_addr;
        wr_data  <= w_sel_data;
        grant_id <= w_sel_id;
      end
      if (w_fire && !w_p0_win) r_ptr <= w_rr_next;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a cycle-level reference model.
module tb_regfile_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;

  logic                clk = 1'b0;
  logic                reset;
  logic                hold;
  logic [N-1:0]        req_valid;
  logic [N-1:0][3:0]   req_addr;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0]        req_ready;
  logic                RegWrite;
  logic [3:0]          wr_addr;
  logic [DW-1:0]       wr_data;
  logic [1:0]          grant_id;
  logic [15:0]         pending_mask;

  regfile_write_arbiter #(
    .NREQ(N), .DATA_W(DW), .P0_PRIORITY(1), .ZERO_REG(1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hold         (hold),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .RegWrite     (RegWrite),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .grant_id     (grant_id),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: round-robin pointer and the write presented to the register file.
  int          m_ptr;
  bit          m_we;
  logic [3:0]  m_addr;
  logic [63:0] m_data;
  int          m_gid;
  int          m_hs;
  bit          chk_on;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant();
    int p;
    if (reset || hold) return -1;
    if (req_valid[0]) return 0;
    for (int k = 0; k < N - 1; k++) begin
      p = 1 + ((m_ptr - 1 + k) % (N - 1));
      if (req_valid[p]) return p;
    end
    return -1;
  endfunction

  task automatic step();
    logic [15:0] ep;
    logic [3:0]  er;
    @(negedge clk);
    m_hs = model_grant();
    er = (m_hs >= 0) ? 4'(1 << m_hs) : 4'b0000;
    ep = '0;
    if (m_we) ep[m_addr] = 1'b1;
    if (m_hs >= 0 && req_addr[m_hs] != 4'hF) ep[req_addr[m_hs]] = 1'b1;
    if (chk_on) begin
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("RegWrite", 64'(RegWrite), 64'(m_we));
      if (m_we) begin
        chk("wr_addr", 64'(wr_addr), 64'(m_addr));
        chk("wr_data", wr_data, m_data);
        chk("grant_id", 64'(grant_id), 64'(m_gid));
      end
      chk("pending_mask", 64'(pending_mask), 64'(ep));
    end
    @(posedge clk);
    if (reset) begin
      m_we = 0; m_addr = '0; m_data = '0; m_gid = 0; m_ptr = 1;
    end else begin
      m_we = (m_hs >= 0) && (req_addr[m_hs] != 4'hF);
      if (m_we) begin
        m_addr = req_addr[m_hs];
        m_data = req_data[m_hs];
        m_gid  = m_hs;
      end
      if (m_hs >= 1) m_ptr = (m_hs % (N - 1)) + 1;
    end
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    reset = 1'b1; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    chk_on = 0; m_ptr = 1; m_we = 0; m_addr = '0; m_data = '0; m_gid = 0; m_hs = -1;
    step();
    chk_on = 1;
    step();
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_regwrite", 64'(RegWrite), 64'd0);
      chk("idle_pending", 64'(pending_mask), 64'd0);
    end
    chk("idle_wr_addr", 64'(wr_addr), 64'd0);
    chk("idle_wr_data", wr_data, 64'd0);
    chk("idle_grant_id", 64'(grant_id), 64'd0);

    // Ports 1..3 continuously valid rotate 1,2,3,1,...
    req_valid = 4'b1110;
    for (int p = 1; p < N; p++) begin
      req_addr[p] = 4'(p);
      req_data[p] = rnd64();
    end
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_grant", 64'(req_ready), 64'(1 << (i % 3 + 1)));
      step();
      chk("rr_wr_addr", 64'(wr_addr), 64'(i % 3 + 1));
      req_data[i % 3 + 1] = rnd64();
    end
    req_valid = '0;
    step();

    // Port 0 priority over port 2
    req_valid = 4'b0101;
    req_addr[0] = 4'd5; req_data[0] = 64'hAA;
    req_addr[2] = 4'd6; req_data[2] = rnd64();
    #1 chk("p0_ready", 64'(req_ready), 64'b0001);
    step();
    req_valid[0] = 1'b0;
    #1;
    chk("p0_wr_addr", 64'(wr_addr), 64'd5);
    chk("p0_wr_data", wr_data, 64'hAA);
    chk("p0_then_p2", 64'(req_ready), 64'b0100);
    step();
    req_valid = '0;

    // Zero-register write handshakes but never commits
    req_valid = 4'b0010; req_addr[1] = 4'hF; req_data[1] = rnd64();
    #1 chk("zr_ready", 64'(req_ready), 64'b0010);
    step();
    req_valid = '0;
    #1;
    chk("zr_regwrite", 64'(RegWrite), 64'd0);
    chk("zr_pending", 64'(pending_mask), 64'd0);
    step();

    // Hold blocks grants; only the write accepted before hold drains
    req_valid = 4'b0010; req_addr[1] = 4'd3; req_data[1] = rnd64();
    step();
    hold = 1'b1; req_valid = 4'b1111;
    for (int p = 0; p < N; p++) begin
      req_addr[p] = 4'(8 + p);
      req_data[p] = rnd64();
    end
    for (int h = 0; h < 3; h++) begin
      #1;
      chk("hold_ready", 64'(req_ready), 64'd0);
      chk("hold_drain", 64'(RegWrite), (h == 0) ? 64'd1 : 64'd0);
      step();
    end
    hold = 1'b0;
    step();
    req_valid = '0;
    step();

    // Reset the cycle after a grant
    req_valid = 4'b0100; req_addr[2] = 4'd7; req_data[2] = rnd64();
    step();
    reset = 1'b1; req_valid = '0;
    step();
    reset = 1'b0;
    #1;
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_pending", 64'(pending_mask), 64'd0);
    req_valid = 4'b1110;
    for (int p = 1; p < N; p++) req_addr[p] = 4'(p);
    #1 chk("rst_ptr", 64'(req_ready), 64'b0010);
    step();
    req_valid = '0;
    step();

    // Randomized traffic with hold and occasional reset
    for (int c = 0; c < 400; c++) begin
      hold  = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < N; p++) begin
        if (!req_valid[p] && $urandom_range(0, 2) != 0) begin
          req_valid[p] = 1'b1;
          req_addr[p]  = 4'($urandom_range(0, 15));
          req_data[p]  = rnd64();
        end
      end
      step();
      if (m_hs >= 0) begin
        req_valid[m_hs] = ($urandom_range(0, 1) == 1);
        req_addr[m_hs]  = 4'($urandom_range(0, 15));
        req_data[m_hs]  = rnd64();
      end
    end
    hold = 1'b0; reset = 1'b0; req_valid = '0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
